// File: rtl/univ_shift_reg_if.sv
// Bundles the universal shift register's control, serial and parallel signals.
// Latency: none; this is wiring only.
// Backpressure: none; busy/done are status outputs. USR_ROTATE_EN adds the rot input.
interface univ_shift_reg_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       mode;
    logic             start;
    logic             burst_dir;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pin;
`ifdef USR_ROTATE_EN
    logic             rot;
`endif
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    // Master side drives the controls and observes the register.
    modport master (
        output mode, start, burst_dir, sin_r, sin_l, pin,
`ifdef USR_ROTATE_EN
        output rot,
`endif
        input  q, sout, busy, done
    );

    // Slave side is the shift register itself.
    modport slave (
        input  mode, start, burst_dir, sin_r, sin_l, pin,
`ifdef USR_ROTATE_EN
        input  rot,
`endif
        output q, sout, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/shift/load plus a WIDTH-shift burst serdes (busy/done).
// Latency: mode ops take 1 edge; a burst is 1 accept edge + WIDTH shifts + 1 done cycle.
// Backpressure: start/mode ignored while busy or done; USR_ROTATE_EN adds rotate-on-rot.
module univ_shift_reg #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    univ_shift_reg_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;
    logic             dir_r, dir_nxt;
    logic             busy_r, done_r;
    logic             sout_c;
    logic             rot_en;
    logic [WIDTH-1:0] q_shr, q_shl;

`ifdef USR_ROTATE_EN
    assign rot_en = bus.rot;
`else
    assign rot_en = 1'b0;
`endif

    // With rotation the bit leaving one end re-enters at the other instead of the serial input.
    assign q_shr = {(rot_en ? q_r[0] : bus.sin_r), q_r[WIDTH-1:1]};
    assign q_shl = {q_r[WIDTH-2:0], (rot_en ? q_r[WIDTH-1] : bus.sin_l)};

    // State and datapath registers; busy/done are flopped from the next state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            q_r    <= '0;
            cnt_r  <= '0;
            dir_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            q_r    <= q_nxt;
            cnt_r  <= cnt_nxt;
            dir_r  <= dir_nxt;
            busy_r <= (state_nxt == ST_BURST);
            done_r <= (state_nxt == ST_DONE);
        end
    end

    // Next-state: start opens a burst, counter value 1 marks the last shift, DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_BURST;
            ST_BURST: if (cnt_r == CNT_W'(1)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and serial output: start takes priority over mode; bursts shift in the latched direction.
    always_comb begin
        q_nxt   = q_r;
        cnt_nxt = cnt_r;
        dir_nxt = dir_r;
        sout_c  = (bus.mode == MODE_SHL) ? q_r[WIDTH-1] : q_r[0];
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    dir_nxt = bus.burst_dir;
                    cnt_nxt = CNT_W'(WIDTH);
                end else begin
                    case (bus.mode)
                        MODE_HOLD: q_nxt = q_r;
                        MODE_SHR:  q_nxt = q_shr;
                        MODE_SHL:  q_nxt = q_shl;
                        MODE_LOAD: q_nxt = bus.pin;
                        default:   q_nxt = q_r;
                    endcase
                end
            end
            ST_BURST: begin
                q_nxt   = dir_r ? q_shl : q_shr;
                cnt_nxt = cnt_r - CNT_W'(1);
                sout_c  = dir_r ? q_r[WIDTH-1] : q_r[0];
            end
            default: begin
                q_nxt = q_r;
            end
        endcase
    end

    assign bus.q    = q_r;
    assign bus.sout = sout_c;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=4: mode table, bursts, reset abort, start priority.
// Latency: inputs driven 1ns after each rising edge, outputs sampled there too.
// Backpressure: waits on done are bounded by a cycle budget.
module tb_univ_shift_reg;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    univ_shift_reg_if #(.WIDTH(4)) bus ();

    univ_shift_reg #(.WIDTH(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic       sin_r;
        logic       sin_l;
        logic [3:0] pin;
        logic       exp_sout;
        logic [3:0] exp_q;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        bus.mode = 2'b11;
        bus.pin  = v;
        step();
        bus.mode = 2'b00;
    endtask

    // Runs a full burst: sbits[i] is the serial bit for shift i, exp_qs nibble i is q after shift i.
    task automatic run_burst(input string nm, input logic dir, input logic [3:0] q0,
                             input logic [3:0] sbits, input logic [3:0] exp_sout,
                             input logic [15:0] exp_qs);
        bus.start     = 1'b1;
        bus.burst_dir = dir;
        bus.mode      = 2'b11;
        bus.pin       = 4'b0000;
        step();
        chk({nm, " accept q"}, 32'(bus.q), 32'(q0));
        chk({nm, " accept busy"}, 32'(bus.busy), 32'd1);
        chk({nm, " accept done"}, 32'(bus.done), 32'd0);
        bus.start     = 1'b0;
        bus.burst_dir = ~dir;
        for (int i = 0; i < 4; i++) begin
            bus.sin_r = sbits[i];
            bus.sin_l = sbits[i];
            #1;
            chk($sformatf("%s sout%0d", nm, i), 32'(bus.sout), 32'(exp_sout[i]));
            step();
            chk($sformatf("%s q%0d", nm, i), 32'(bus.q), 32'(exp_qs[i*4 +: 4]));
            chk($sformatf("%s busy%0d", nm, i), 32'(bus.busy), (i < 3) ? 32'd1 : 32'd0);
            chk($sformatf("%s done%0d", nm, i), 32'(bus.done), (i == 3) ? 32'd1 : 32'd0);
        end
        step();
        chk({nm, " done falls"}, 32'(bus.done), 32'd0);
        chk({nm, " idle busy"}, 32'(bus.busy), 32'd0);
        chk({nm, " final q"}, 32'(bus.q), 32'(exp_qs[15:12]));
        bus.mode = 2'b00;
    endtask

    initial begin
        bit seen;
        vecs[0] = '{2'b11, 1'b0, 1'b0, 4'b1011, 1'b0, 4'b1011};
        vecs[1] = '{2'b00, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b1011};
        vecs[2] = '{2'b00, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1011};
        vecs[3] = '{2'b00, 1'b0, 1'b1, 4'b0101, 1'b1, 4'b1011};
        vecs[4] = '{2'b01, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b1101};
        vecs[5] = '{2'b10, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b1010};
        vecs[6] = '{2'b01, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0101};
        vecs[7] = '{2'b10, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b1011};
        vecs[8] = '{2'b11, 1'b1, 1'b1, 4'b0110, 1'b1, 4'b0110};
        vecs[9] = '{2'b10, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b1101};

        rst           = 1'b0;
        bus.mode      = 2'b00;
        bus.start     = 1'b0;
        bus.burst_dir = 1'b0;
        bus.sin_r     = 1'b0;
        bus.sin_l     = 1'b0;
        bus.pin       = 4'b0000;
`ifdef USR_ROTATE_EN
        bus.rot       = 1'b0;
`endif
        step();
        rst = 1'b1;

        // Reset clears a loaded value and dominates a simultaneous load.
        load(4'b1010);
        chk("pre-reset load", 32'(bus.q), 32'hA);
        rst = 1'b0;
        step();
        chk("reset q", 32'(bus.q), 32'h0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        bus.mode = 2'b11;
        bus.pin  = 4'b1111;
        step();
        chk("reset beats load", 32'(bus.q), 32'h0);
        rst      = 1'b1;
        bus.mode = 2'b00;

        // Idle-mode vector table.
        for (int i = 0; i < 10; i++) begin
            bus.mode  = vecs[i].mode;
            bus.sin_r = vecs[i].sin_r;
            bus.sin_l = vecs[i].sin_l;
            bus.pin   = vecs[i].pin;
            #1;
            chk($sformatf("vec%0d sout", i), 32'(bus.sout), 32'(vecs[i].exp_sout));
            step();
            chk($sformatf("vec%0d q", i), 32'(bus.q), 32'(vecs[i].exp_q));
        end
        bus.mode = 2'b00;

        // Right burst on 1011 with serial 0,1,1,0; then left burst on the result with 1,0,0,1.
        load(4'b1011);
        run_burst("rburst", 1'b0, 4'b1011, 4'b0110, 4'b1011, 16'h6DA5);
        run_burst("lburst", 1'b1, 4'b0110, 4'b1001, 4'b0110, 16'h94AD);

        // Reset at the second burst shift aborts with no done pulse.
        load(4'b1011);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.sin_r = 1'b0;
        step();
        chk("abort shift1 q", 32'(bus.q), 32'h5);
        rst = 1'b0;
        step();
        chk("abort q", 32'(bus.q), 32'h0);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("abort no done %0d", i), 32'(bus.done | bus.busy), 32'd0);
        end

        // Start beats load; start held high is ignored in DONE and re-accepted one edge later.
        load(4'b0110);
        bus.start     = 1'b1;
        bus.burst_dir = 1'b0;
        bus.mode      = 2'b11;
        bus.pin       = 4'b1111;
        step();
        chk("prio q", 32'(bus.q), 32'h6);
        chk("prio busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 3; i++) step();
        chk("prio still busy", 32'(bus.busy), 32'd1);
        step();
        chk("prio done", 32'(bus.done), 32'd1);
        step();
        chk("prio gap busy", 32'(bus.busy), 32'd0);
        chk("prio gap done", 32'(bus.done), 32'd0);
        step();
        chk("prio restart busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (bus.done) seen = 1'b1;
        end
        chk("prio restart done seen", 32'(seen), 32'd1);
        step();

`ifdef USR_ROTATE_EN
        load(4'b1001);
        bus.rot   = 1'b1;
        bus.mode  = 2'b01;
        bus.sin_r = 1'b0;
        step();
        chk("rot shr", 32'(bus.q), 32'hC);
        bus.mode = 2'b00;
        load(4'b1001);
        bus.rot = 1'b1;
        run_burst("rotl", 1'b1, 4'b1001, 4'b0000, 4'b1001, 16'h9C63);
        bus.rot = 1'b0;
`else
        load(4'b1001);
        bus.mode  = 2'b01;
        bus.sin_r = 1'b0;
        step();
        chk("plain shr", 32'(bus.q), 32'h4);
        bus.mode = 2'b00;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
